// File: rtl/pair_tx.sv
// Dual-channel (x,y) byte-pair transmitter: FIFO front end feeding two 4-phase dav/rfd channels.
// Optional completed-pair counter on sent_cnt when PAIR_TX_STATS_EN is defined.
module pair_tx #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din_x,
  input  logic [7:0] din_y,
  output logic       full,
  output logic       empty,
  output logic [7:0] x,
  output logic       dav_x,
  input  logic       rfd_x,
  output logic [7:0] y,
  output logic       dav_y,
  input  logic       rfd_y
`ifdef PAIR_TX_STATS_EN
  ,
  output logic [15:0] sent_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OFFER = 2'd1;
  localparam logic [1:0] CLOSE = 2'd2;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          dav_x_q, dav_x_d, dav_y_q, dav_y_d;
  logic [7:0]    x_q, x_d, y_q, y_d;
  logic          wr_en, load, pop;
  logic [15:0]   head;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  // full is taken from the pre-pop count, so a push while full is rejected even on a pop edge
  assign wr_en = push & ~full;
  assign head  = mem[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    dav_x_d = dav_x_q;
    dav_y_d = dav_y_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        dav_x_d = 1'b0;
        dav_y_d = 1'b0;
        if (!empty && rfd_x && rfd_y) begin
          load    = 1'b1;
          dav_x_d = 1'b1;
          dav_y_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // a channel is done once its dav has been cleared
        if (!rfd_x) dav_x_d = 1'b0;
        if (!rfd_y) dav_y_d = 1'b0;
        if (!dav_x_d && !dav_y_d) state_d = CLOSE;
      end
      CLOSE: begin
        dav_x_d = 1'b0;
        dav_y_d = 1'b0;
        if (rfd_x && rfd_y) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        dav_x_d = 1'b0;
        dav_y_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign x_d      = load ? head[15:8] : x_q;
  assign y_d      = load ? head[7:0]  : y_q;
  assign wr_ptr_d = wr_ptr_q + PW'(wr_en);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign count_d  = count_q + (PW+1)'(wr_en) - (PW+1)'(pop);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= {din_x, din_y};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      dav_x_q  <= 1'b0;
      dav_y_q  <= 1'b0;
      x_q      <= 8'h00;
      y_q      <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      dav_x_q  <= dav_x_d;
      dav_y_q  <= dav_y_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign dav_x = dav_x_q;
  assign dav_y = dav_y_q;

`ifdef PAIR_TX_STATS_EN
  logic [15:0] sent_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)    sent_q <= 16'h0000;
    else if (pop) sent_q <= sent_q + 16'h0001;
  end

  assign sent_cnt = sent_q;
`endif

endmodule

// File: tb/tb_pair_tx.sv
// Directed testbench for pair_tx: handshake timing, FIFO full/empty edges, same-edge push/pop, reset.
module tb_pair_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       push  = 1'b0;
  logic [7:0] din_x = 8'h00;
  logic [7:0] din_y = 8'h00;
  logic       full, empty, dav_x, dav_y;
  logic [7:0] x, y;
  logic       rfd_x = 1'b1;
  logic       rfd_y = 1'b1;
`ifdef PAIR_TX_STATS_EN
  logic [15:0] sent_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pair_tx #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .push(push), .din_x(din_x), .din_y(din_y),
    .full(full), .empty(empty), .x(x), .dav_x(dav_x), .rfd_x(rfd_x),
    .y(y), .dav_y(dav_y), .rfd_y(rfd_y)
`ifdef PAIR_TX_STATS_EN
    , .sent_cnt(sent_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef PAIR_TX_STATS_EN
  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
`endif

  task automatic do_push(input logic [7:0] px, input logic [7:0] py);
    push = 1'b1; din_x = px; din_y = py;
    step();
    push = 1'b0;
  endtask

  // Expects IDLE with rfd high on entry; completes one transfer and returns in IDLE.
  task automatic drain_one(input string tag, input logic [7:0] ex, input logic [7:0] ey);
    int waited = 0;
    rfd_x = 1'b1; rfd_y = 1'b1;
    while (dav_x !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    chk1({tag, "_dav_seen"}, dav_x, 1'b1);
    chk8({tag, "_x"}, x, ex);
    chk8({tag, "_y"}, y, ey);
    rfd_x = 1'b0; rfd_y = 1'b0;
    step();
    rfd_x = 1'b1; rfd_y = 1'b1;
    step();
  endtask

  initial begin
    // reset values
    #12;
    chk1("rst_dav_x", dav_x, 1'b0);
    chk1("rst_dav_y", dav_y, 1'b0);
    chk8("rst_x", x, 8'h00);
    chk8("rst_y", y, 8'h00);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
`ifdef PAIR_TX_STATS_EN
    chk16("rst_sent", sent_cnt, 16'h0000);
`endif
    step();
    reset = 1'b0;
    step();

    // basic transfer: push at edge k, dav after k+1
    do_push(8'h12, 8'h34);
    chk1("t1_dav_early", dav_x, 1'b0);
    chk1("t1_not_empty", empty, 1'b0);
    step();
    chk1("t1_dav_x", dav_x, 1'b1);
    chk1("t1_dav_y", dav_y, 1'b1);
    chk8("t1_x", x, 8'h12);
    chk8("t1_y", y, 8'h34);
    rfd_x = 1'b0; rfd_y = 1'b0;
    step();
    chk1("t1_dav_x_drop", dav_x, 1'b0);
    chk1("t1_dav_y_drop", dav_y, 1'b0);
    chk1("t1_no_pop_yet", empty, 1'b0);
    rfd_x = 1'b1; rfd_y = 1'b1;
    step();
    chk1("t1_popped", empty, 1'b1);
`ifdef PAIR_TX_STATS_EN
    chk16("t1_sent", sent_cnt, 16'h0001);
`endif

    // rfd low in IDLE while dav is low has no effect
    rfd_x = 1'b0;
    step();
    chk1("idle_viol_dav", dav_x, 1'b0);
    rfd_x = 1'b1;

    // staggered acknowledges
    do_push(8'h56, 8'h78);
    step();
    chk8("t2_x", x, 8'h56);
    rfd_x = 1'b0;
    step();
    chk1("t2_dav_x_drop", dav_x, 1'b0);
    chk1("t2_dav_y_hold1", dav_y, 1'b1);
    step();
    chk1("t2_dav_y_hold2", dav_y, 1'b1);
    rfd_y = 1'b0;
    step();
    chk1("t2_dav_y_drop", dav_y, 1'b0);
    rfd_x = 1'b1;
    step();
    chk1("t2_close_dav_x", dav_x, 1'b0);
    chk1("t2_no_pop_partial", empty, 1'b0);
    rfd_y = 1'b1;
    step();
    chk1("t2_popped", empty, 1'b1);
    chk8("t2_x_hold", x, 8'h56);
`ifdef PAIR_TX_STATS_EN
    chk16("t2_sent", sent_cnt, 16'h0002);
`endif

    // overflow: 5 pushes with consumer stalled, 5th dropped
    rfd_x = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_push(8'hA0 + 8'(i), 8'hB0 + 8'(i));
      if (i == 2) chk1("t3_full_after3", full, 1'b0);
      if (i == 3) chk1("t3_full_after4", full, 1'b1);
    end
    chk1("t3_full_after5", full, 1'b1);
    chk1("t3_stalled_dav", dav_x, 1'b0);
    for (int i = 0; i < 4; i++) drain_one("t3_drain", 8'hA0 + 8'(i), 8'hB0 + 8'(i));
    chk1("t3_empty", empty, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk1("t3_no_5th", dav_x, 1'b0);

    // push on pop edge: rejected at count=4, accepted at count=3
    rfd_x = 1'b0;
    for (int i = 0; i < 4; i++) do_push(8'hC0 + 8'(i), 8'hC8 + 8'(i));
    chk1("t4_full", full, 1'b1);
    rfd_x = 1'b1;
    step();
    chk8("t4_x_c0", x, 8'hC0);
    rfd_x = 1'b0; rfd_y = 1'b0;
    step();
    rfd_x = 1'b1; rfd_y = 1'b1;
    do_push(8'hEE, 8'hEE);
    chk1("t4_rej_full", full, 1'b0);
    step();
    chk8("t4_x_c1", x, 8'hC1);
    rfd_x = 1'b0; rfd_y = 1'b0;
    step();
    rfd_x = 1'b1; rfd_y = 1'b1;
    do_push(8'hD5, 8'hD6);
    chk1("t4_cnt3_full", full, 1'b0);
    chk1("t4_cnt3_empty", empty, 1'b0);
    drain_one("t4_c2", 8'hC2, 8'hCA);
    drain_one("t4_c3", 8'hC3, 8'hCB);
    drain_one("t4_d5", 8'hD5, 8'hD6);
    chk1("t4_empty", empty, 1'b1);

    // reset mid-OFFER
    do_push(8'h11, 8'h22);
    do_push(8'h99, 8'h88);
    chk1("t5_offer_dav", dav_x, 1'b1);
    reset = 1'b1;
    #1;
    chk1("t5_async_dav_x", dav_x, 1'b0);
    chk1("t5_async_dav_y", dav_y, 1'b0);
    chk1("t5_empty", empty, 1'b1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk1("t5_no_delivery", dav_x, 1'b0);
`ifdef PAIR_TX_STATS_EN
    chk16("t5_sent_clr", sent_cnt, 16'h0000);
`endif
    do_push(8'h33, 8'h44);
    drain_one("t5_new", 8'h33, 8'h44);

`ifdef PAIR_TX_STATS_EN
    // counter wrap
    force dut.sent_q = 16'hFFFF;
    #1;
    release dut.sent_q;
    chk16("t6_preload", sent_cnt, 16'hFFFF);
    do_push(8'h5A, 8'hA5);
    drain_one("t6_pair", 8'h5A, 8'hA5);
    chk16("t6_wrap", sent_cnt, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
